// File: rtl/pipeline_defs.sv
// Shared definitions for the EX-stage forwarding/hazard control slice.
// Provides the operand-mux select encoding, the hazard FSM state encoding
// and default widths used by forward_hazard_unit and fwd_select.
package pipeline_defs;

  // Operand-mux select encoding; 2'd3 is never produced.
  localparam logic [1:0] FWD_RF    = 2'd0;  // register-file value
  localparam logic [1:0] FWD_MEMWB = 2'd1;  // MEM/WB writeback data
  localparam logic [1:0] FWD_EXMEM = 2'd2;  // EX/MEM ALU result

  localparam int REG_ADDR_W_DFLT = 5;
  localparam int CNT_W_DFLT      = 32;

  // Stage record field widths beyond the destination address.
  localparam int REC_FLAG_W = 2;  // {regwrite, memread}

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } hz_state_e;

endpackage

// File: rtl/fwd_select.sv
// Priority comparator producing one operand-mux select.
// Ports:
//   src_i          source register read by the ID instruction
//   ex_dest_i      destination held in the EX shadow record
//   ex_regwrite_i  EX record writes the register file
//   mem_dest_i     destination held in the MEM shadow record
//   mem_regwrite_i MEM record writes the register file
//   kill_i         a bubble is entering EX; force the register-file select
//   sel_o          next select value (FWD_RF / FWD_MEMWB / FWD_EXMEM)
module fwd_select
  import pipeline_defs::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DFLT
) (
  input  logic [REG_ADDR_W-1:0] src_i,
  input  logic [REG_ADDR_W-1:0] ex_dest_i,
  input  logic                  ex_regwrite_i,
  input  logic [REG_ADDR_W-1:0] mem_dest_i,
  input  logic                  mem_regwrite_i,
  input  logic                  kill_i,
  output logic [1:0]            sel_o
);

  logic ex_hit;
  logic mem_hit;

  // $0 is hard-wired, so a "write" to it must never be forwarded.
  assign ex_hit  = ex_regwrite_i  && (ex_dest_i  != '0) && (ex_dest_i  == src_i);
  assign mem_hit = mem_regwrite_i && (mem_dest_i != '0) && (mem_dest_i == src_i);

  // The newer producer (the one now in EX) holds the most recent value.
  always_comb begin
    sel_o = FWD_RF;
    if (!kill_i) begin
      if (ex_hit) begin
        sel_o = FWD_EXMEM;
      end else if (mem_hit) begin
        sel_o = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/forward_hazard_unit.sv
// Forwarding and load-use hazard control for the EX-stage operand muxes.
// Keeps shadow destination records for EX, MEM and WB, registers the
// operand-A/B forwarding selects one cycle ahead of EX, and stalls PC and
// IF/ID for one cycle on a load-use dependency while counting stall cycles.
// Ports:
//   Clk, Reset          pipeline clock, synchronous active-low reset
//   hold                global freeze: all internal state holds
//   id_rs/id_rt         source registers of the ID instruction
//   id_use_rs/id_use_rt ID instruction actually reads rs / rt
//   id_dest             destination of the ID instruction
//   id_regwrite         ID instruction writes the register file
//   id_memread          ID instruction is a load
//   id_flush            ID instruction is squashed by a taken branch
//   fwd_a_sel/fwd_b_sel registered operand-mux selects
//   pc_write/ifid_write front-end write enables (low during a stall)
//   idex_bubble         ID/EX loads a NOP
//   stall_count         saturating count of load-use stall cycles
module forward_hazard_unit
  import pipeline_defs::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DFLT,
  parameter int CNT_W      = CNT_W_DFLT
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  hold,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_use_rs,
  input  logic                  id_use_rt,
  input  logic [REG_ADDR_W-1:0] id_dest,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  id_flush,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  idex_bubble,
  output logic [CNT_W-1:0]      stall_count
);

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic                  regwrite;
    logic                  memread;
  } stage_rec_t;

  localparam stage_rec_t BUBBLE = '0;

  stage_rec_t ex_q, mem_q, wb_q;
  stage_rec_t ex_d;
  hz_state_e  state_q, state_d;
  logic [1:0] sel_a_q, sel_b_q, sel_a_d, sel_b_d;
  logic [CNT_W-1:0] cnt_q;

  logic load_use;
  logic kill;

  // wb_q is kept for completeness of the shadow pipeline; forwarding from
  // WB to ID is handled by the register file's write-then-read timing.
  logic unused_wb;
  assign unused_wb = ^wb_q;

  assign load_use = ex_q.memread && (ex_q.dest != '0) &&
                    ((id_use_rs && (id_rs == ex_q.dest)) ||
                     (id_use_rt && (id_rt == ex_q.dest))) &&
                    !id_flush;

  assign kill = load_use || id_flush;

  assign pc_write    = !load_use;
  assign ifid_write  = !load_use;
  assign idex_bubble = kill;

  assign ex_d = kill ? BUBBLE : '{dest: id_dest, regwrite: id_regwrite, memread: id_memread};

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_sel_a (
    .src_i          (id_rs),
    .ex_dest_i      (ex_q.dest),
    .ex_regwrite_i  (ex_q.regwrite),
    .mem_dest_i     (mem_q.dest),
    .mem_regwrite_i (mem_q.regwrite),
    .kill_i         (kill),
    .sel_o          (sel_a_d)
  );

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_sel_b (
    .src_i          (id_rt),
    .ex_dest_i      (ex_q.dest),
    .ex_regwrite_i  (ex_q.regwrite),
    .mem_dest_i     (mem_q.dest),
    .mem_regwrite_i (mem_q.regwrite),
    .kill_i         (kill),
    .sel_o          (sel_b_d)
  );

  // The bubble injected on entry to STALL clears the load out of EX, so
  // load_use drops by itself; the FSM still guarantees a single stall cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (load_use && !hold) state_d = STALL;
      STALL:   if (!hold)             state_d = RUN;
      default:                        state_d = RUN;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      ex_q    <= BUBBLE;
      mem_q   <= BUBBLE;
      wb_q    <= BUBBLE;
      state_q <= RUN;
      sel_a_q <= FWD_RF;
      sel_b_q <= FWD_RF;
      cnt_q   <= '0;
    end else if (!hold) begin
      wb_q    <= mem_q;
      mem_q   <= ex_q;
      ex_q    <= ex_d;
      state_q <= state_d;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
      if (load_use && !(&cnt_q)) begin
        cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign fwd_a_sel   = sel_a_q;
  assign fwd_b_sel   = sel_b_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_forward_hazard_unit.sv
module tb_forward_hazard_unit;

  localparam int AW = 5;
  localparam int CW = 3;

  logic          Clk;
  logic          Reset;
  logic          hold;
  logic [AW-1:0] id_rs, id_rt, id_dest;
  logic          id_use_rs, id_use_rt, id_regwrite, id_memread, id_flush;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic          pc_write, ifid_write, idex_bubble;
  logic [CW-1:0] stall_count;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;

  forward_hazard_unit #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .hold        (hold),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .id_dest     (id_dest),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .id_flush    (id_flush),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel),
    .pc_write    (pc_write),
    .ifid_write  (ifid_write),
    .idex_bubble (idex_bubble),
    .stall_count (stall_count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic set_id(input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                        input logic urs, input logic urt,
                        input logic [AW-1:0] dest, input logic rw,
                        input logic mr, input logic fl);
    id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_dest = dest; id_regwrite = rw; id_memread = mr; id_flush = fl;
    #1;
  endtask

  task automatic nops();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  task automatic test_reset();
    Reset = 1'b0; hold = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    total++; if (fwd_a_sel !== 2'd0) begin bad++; $display("FAIL reset_fwd_a: got %0d want 0", fwd_a_sel); end
    total++; if (fwd_b_sel !== 2'd0) begin bad++; $display("FAIL reset_fwd_b: got %0d want 0", fwd_b_sel); end
    total++; if (pc_write !== 1'b1) begin bad++; $display("FAIL reset_pc_write: got %0b want 1", pc_write); end
    total++; if (ifid_write !== 1'b1) begin bad++; $display("FAIL reset_ifid_write: got %0b want 1", ifid_write); end
    total++; if (idex_bubble !== 1'b0) begin bad++; $display("FAIL reset_bubble: got %0b want 0", idex_bubble); end
    total++; if (stall_count !== 3'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", stall_count); end
    Reset = 1'b1;
  endtask

  // add $3,$1,$2 ; add $4,$3,$5
  task automatic test_fwd_exmem();
    nops();
    set_id(1, 2, 1, 1, 3, 1, 0, 0); tick();
    set_id(3, 5, 1, 1, 4, 1, 0, 0);
    total++; if (pc_write !== 1'b1) begin bad++; $display("FAIL exmem_no_stall: got %0b want 1", pc_write); end
    total++; if (idex_bubble !== 1'b0) begin bad++; $display("FAIL exmem_no_bubble: got %0b want 0", idex_bubble); end
    tick();
    total++; if (fwd_a_sel !== 2'd2) begin bad++; $display("FAIL exmem_fwd_a: got %0d want 2", fwd_a_sel); end
    total++; if (fwd_b_sel !== 2'd0) begin bad++; $display("FAIL exmem_fwd_b: got %0d want 0", fwd_b_sel); end
  endtask

  // add $3 ; nop ; sub $6,$7,$3, then add $3 ; add $3 ; use $3,$3
  task automatic test_fwd_memwb();
    nops();
    set_id(1, 2, 1, 1, 3, 1, 0, 0); tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0); tick();
    set_id(7, 3, 1, 1, 6, 1, 0, 0); tick();
    total++; if (fwd_a_sel !== 2'd0) begin bad++; $display("FAIL memwb_fwd_a: got %0d want 0", fwd_a_sel); end
    total++; if (fwd_b_sel !== 2'd1) begin bad++; $display("FAIL memwb_fwd_b: got %0d want 1", fwd_b_sel); end
    nops();
    set_id(1, 2, 1, 1, 3, 1, 0, 0); tick();
    set_id(0, 0, 0, 0, 3, 1, 0, 0); tick();
    set_id(3, 3, 1, 1, 10, 1, 0, 0); tick();
    total++; if (fwd_a_sel !== 2'd2) begin bad++; $display("FAIL prio_fwd_a: got %0d want 2", fwd_a_sel); end
    total++; if (fwd_b_sel !== 2'd2) begin bad++; $display("FAIL prio_fwd_b: got %0d want 2", fwd_b_sel); end
  endtask

  // lw $8 ; add $9,$8,$8
  task automatic test_load_use();
    nops();
    set_id(29, 0, 1, 0, 8, 1, 1, 0); tick();
    set_id(8, 8, 1, 1, 9, 1, 0, 0);
    total++; if (pc_write !== 1'b0) begin bad++; $display("FAIL lu_pc_write: got %0b want 0", pc_write); end
    total++; if (ifid_write !== 1'b0) begin bad++; $display("FAIL lu_ifid_write: got %0b want 0", ifid_write); end
    total++; if (idex_bubble !== 1'b1) begin bad++; $display("FAIL lu_bubble: got %0b want 1", idex_bubble); end
    tick();
    exp_cnt = 1;
    total++; if (pc_write !== 1'b1) begin bad++; $display("FAIL lu_release_pc: got %0b want 1", pc_write); end
    total++; if (idex_bubble !== 1'b0) begin bad++; $display("FAIL lu_release_bubble: got %0b want 0", idex_bubble); end
    total++; if (stall_count !== exp_cnt[CW-1:0]) begin bad++; $display("FAIL lu_count: got %0d want %0d", stall_count, exp_cnt); end
    total++; if (fwd_a_sel !== 2'd0) begin bad++; $display("FAIL lu_bubble_sel: got %0d want 0", fwd_a_sel); end
    tick();
    total++; if (fwd_a_sel !== 2'd1) begin bad++; $display("FAIL lu_fwd_a: got %0d want 1", fwd_a_sel); end
    total++; if (fwd_b_sel !== 2'd1) begin bad++; $display("FAIL lu_fwd_b: got %0d want 1", fwd_b_sel); end
  endtask

  task automatic test_zero_reg();
    nops();
    set_id(1, 2, 1, 1, 0, 1, 0, 0); tick();
    set_id(0, 0, 1, 1, 1, 1, 0, 0); tick();
    total++; if (fwd_a_sel !== 2'd0) begin bad++; $display("FAIL zero_fwd_a: got %0d want 0", fwd_a_sel); end
    total++; if (fwd_b_sel !== 2'd0) begin bad++; $display("FAIL zero_fwd_b: got %0d want 0", fwd_b_sel); end
    nops();
    set_id(29, 0, 1, 0, 0, 1, 1, 0); tick();
    set_id(0, 0, 1, 1, 2, 1, 0, 0);
    total++; if (pc_write !== 1'b1) begin bad++; $display("FAIL zero_lw_stall: got %0b want 1", pc_write); end
    tick();
    total++; if (stall_count !== exp_cnt[CW-1:0]) begin bad++; $display("FAIL zero_lw_count: got %0d want %0d", stall_count, exp_cnt); end
  endtask

  task automatic test_flush();
    nops();
    set_id(29, 0, 1, 0, 8, 1, 1, 0); tick();
    set_id(8, 8, 1, 1, 9, 1, 0, 1);
    total++; if (pc_write !== 1'b1) begin bad++; $display("FAIL flush_pc_write: got %0b want 1", pc_write); end
    total++; if (ifid_write !== 1'b1) begin bad++; $display("FAIL flush_ifid_write: got %0b want 1", ifid_write); end
    total++; if (idex_bubble !== 1'b1) begin bad++; $display("FAIL flush_bubble: got %0b want 1", idex_bubble); end
    tick();
    total++; if (stall_count !== exp_cnt[CW-1:0]) begin bad++; $display("FAIL flush_count: got %0d want %0d", stall_count, exp_cnt); end
    total++; if (fwd_a_sel !== 2'd0) begin bad++; $display("FAIL flush_sel: got %0d want 0", fwd_a_sel); end
  endtask

  task automatic test_reset_mid();
    nops();
    set_id(1, 2, 1, 1, 3, 1, 0, 0); tick();
    set_id(3, 0, 1, 0, 8, 1, 1, 0); tick();
    total++; if (fwd_a_sel !== 2'd2) begin bad++; $display("FAIL midrst_pre_sel: got %0d want 2", fwd_a_sel); end
    set_id(8, 8, 1, 1, 9, 1, 0, 0);
    total++; if (pc_write !== 1'b0) begin bad++; $display("FAIL midrst_pre_stall: got %0b want 0", pc_write); end
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    #1;
    exp_cnt = 0;
    total++; if (fwd_a_sel !== 2'd0) begin bad++; $display("FAIL midrst_fwd_a: got %0d want 0", fwd_a_sel); end
    total++; if (fwd_b_sel !== 2'd0) begin bad++; $display("FAIL midrst_fwd_b: got %0d want 0", fwd_b_sel); end
    total++; if (pc_write !== 1'b1) begin bad++; $display("FAIL midrst_pc_write: got %0b want 1", pc_write); end
    total++; if (stall_count !== 3'd0) begin bad++; $display("FAIL midrst_count: got %0d want 0", stall_count); end
    tick();
    total++; if (stall_count !== 3'd0) begin bad++; $display("FAIL midrst_no_stall: got %0d want 0", stall_count); end
  endtask

  task automatic test_hold();
    nops();
    set_id(1, 2, 1, 1, 3, 1, 0, 0); tick();
    set_id(3, 0, 1, 0, 8, 1, 1, 0); tick();
    total++; if (fwd_a_sel !== 2'd2) begin bad++; $display("FAIL hold_pre_sel: got %0d want 2", fwd_a_sel); end
    set_id(8, 8, 1, 1, 9, 1, 0, 0);
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (fwd_a_sel !== 2'd2) begin bad++; $display("FAIL hold_sel[%0d]: got %0d want 2", i, fwd_a_sel); end
      total++; if (stall_count !== exp_cnt[CW-1:0]) begin bad++; $display("FAIL hold_count[%0d]: got %0d want %0d", i, stall_count, exp_cnt); end
      total++; if (pc_write !== 1'b0) begin bad++; $display("FAIL hold_pc_write[%0d]: got %0b want 0", i, pc_write); end
    end
    hold = 1'b0;
    tick();
    exp_cnt = exp_cnt + 1;
    total++; if (stall_count !== exp_cnt[CW-1:0]) begin bad++; $display("FAIL hold_release_count: got %0d want %0d", stall_count, exp_cnt); end
    total++; if (fwd_a_sel !== 2'd0) begin bad++; $display("FAIL hold_release_sel: got %0d want 0", fwd_a_sel); end
    total++; if (pc_write !== 1'b1) begin bad++; $display("FAIL hold_release_pc: got %0b want 1", pc_write); end
  endtask

  task automatic test_saturate();
    nops();
    for (int i = 0; i < 8; i++) begin
      set_id(0, 0, 0, 0, 8, 1, 1, 0); tick();
      set_id(8, 0, 1, 0, 9, 1, 0, 0); tick();
      if (exp_cnt < 7) exp_cnt = exp_cnt + 1;
      total++; if (stall_count !== exp_cnt[CW-1:0]) begin bad++; $display("FAIL sat_count[%0d]: got %0d want %0d", i, stall_count, exp_cnt); end
      tick();
    end
    total++; if (stall_count !== 3'd7) begin bad++; $display("FAIL sat_final: got %0d want 7", stall_count); end
  endtask

  initial begin
    Reset = 1'b0; hold = 1'b0;
    id_rs = '0; id_rt = '0; id_dest = '0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; id_regwrite = 1'b0; id_memread = 1'b0; id_flush = 1'b0;
    test_reset();
    test_fwd_exmem();
    test_fwd_memwb();
    test_load_use();
    test_zero_reg();
    test_flush();
    test_reset_mid();
    test_hold();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
